// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: parses start/PB/LB/count/payload frames and streams payload bits to the broadcaster
module serial_frame_receiver #(
  parameter int PB_W  = 4,
  parameter int LB_W  = 2,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            serIn,
  output logic [PB_W-1:0] PB,
  output logic [LB_W-1:0] LB,
  output logic            serOut,
  output logic            valid,
  output logic            done,
  output logic            busy
);
  localparam int BC_W = (CNT_W > PB_W) ? ((CNT_W > LB_W) ? CNT_W : LB_W)
                                       : ((PB_W > LB_W) ? PB_W : LB_W);
  typedef enum logic [2:0] {IDLE, PORT, LINE, CNT, DATA, DONE} state_t;
  state_t            state, nextState;
  logic [BC_W-1:0]   bitCnt;
  logic [PB_W-1:0]   pbReg, pbShift, pbNext;
  logic [LB_W-1:0]   lbReg, lbShift, lbNext;
  logic [CNT_W-1:0]  cntReg, cntShift;
  logic              fieldEnd, validNext, serOutNext, doneNext;
  // Fields arrive LSB first, so each new bit enters at the top and shifts down.
  assign pbShift  = PB_W'({serIn, pbReg} >> 1);
  assign lbShift  = LB_W'({serIn, lbReg} >> 1);
  assign cntShift = CNT_W'({serIn, cntReg} >> 1);
  assign fieldEnd = (state == PORT && bitCnt == BC_W'(PB_W - 1)) ||
                    (state == LINE && bitCnt == BC_W'(LB_W - 1)) ||
                    (state == CNT  && bitCnt == BC_W'(CNT_W - 1)) ||
                    (state == DATA && bitCnt == BC_W'(cntReg) - BC_W'(1));
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nextState;
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = serIn ? IDLE : PORT;
      PORT:    nextState = fieldEnd ? LINE : PORT;
      LINE:    nextState = fieldEnd ? CNT : LINE;
      CNT:     nextState = fieldEnd ? ((cntShift != '0) ? DATA : DONE) : CNT;
      DATA:    nextState = fieldEnd ? DONE : DATA;
      default: nextState = IDLE;
    endcase
  end
  always_comb begin
    validNext  = state == DATA;
    serOutNext = validNext & serIn;
    pbNext     = validNext ? pbReg : '0;
    lbNext     = validNext ? lbReg : '0;
    doneNext   = fieldEnd && (state == DATA || (state == CNT && cntShift == '0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bitCnt <= '0;
      pbReg  <= '0;
      lbReg  <= '0;
      cntReg <= '0;
      PB     <= '0;
      LB     <= '0;
      serOut <= 1'b0;
      valid  <= 1'b0;
      done   <= 1'b0;
    end else begin
      bitCnt <= (state == IDLE || fieldEnd) ? '0 : bitCnt + BC_W'(1);
      pbReg  <= (state == IDLE) ? '0 : (state == PORT) ? pbShift : pbReg;
      lbReg  <= (state == IDLE) ? '0 : (state == LINE) ? lbShift : lbReg;
      cntReg <= (state == IDLE) ? '0 : (state == CNT) ? cntShift : cntReg;
      PB     <= pbNext;
      LB     <= lbNext;
      serOut <= serOutNext;
      valid  <= validNext;
      done   <= doneNext;
    end
  end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: frame-level reference model over a prebuilt serIn/rst stream, compared every cycle
module tb_serial_frame_receiver;
  localparam int MAXL = 2048;
  localparam int PAD  = 64;
  localparam int HDR  = 11;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serIn = 1'b1;
  logic [3:0] PB;
  logic [1:0] LB;
  logic       serOut, valid, done, busy;
  serial_frame_receiver dut (
    .clk(clk), .rst(rst), .serIn(serIn), .PB(PB), .LB(LB),
    .serOut(serOut), .valid(valid), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  logic       s [MAXL+PAD];
  logic       r [MAXL+PAD];
  logic [9:0] expVec [MAXL+PAD];
  int         streamLen = 0;
  int         curEdge = 0;
  int         nCmp = 0;
  int         nBad = 0;
  int         lastStart = 0;
  logic       running = 1'b0;
  task automatic pushBit(input logic b, input logic rv);
    if (streamLen < MAXL) begin
      s[streamLen] = b;
      r[streamLen] = rv;
      streamLen++;
    end
  endtask
  task automatic pushFrame(input logic [3:0] pb, input logic [1:0] lb, input int n,
                           input logic [15:0] d, input logic doneBit, input int rstAt);
    logic q[$];
    logic [3:0] nn;
    nn = 4'(n);
    q.push_back(1'b0);
    for (int b = 0; b < 4; b++) q.push_back(pb[b]);
    for (int b = 0; b < 2; b++) q.push_back(lb[b]);
    for (int b = 0; b < 4; b++) q.push_back(nn[b]);
    for (int k = 0; k < n; k++) q.push_back(d[k]);
    q.push_back(doneBit);
    lastStart = streamLen;
    for (int j = 0; j < q.size(); j++) begin
      pushBit(q[j], j == rstAt);
      if (j == rstAt) return;
    end
  endtask
  task automatic buildModel();
    int i, t, n, last, rs;
    logic [3:0] pb;
    logic [1:0] lb;
    logic pay;
    for (int e = 0; e < MAXL + PAD; e++) expVec[e] = '0;
    i = 0;
    while (i < streamLen) begin
      if (r[i] || s[i]) begin
        i++;
      end else begin
        t = i;
        n = 0;
        for (int b = 0; b < 4; b++) pb[b] = s[t+1+b];
        for (int b = 0; b < 2; b++) lb[b] = s[t+5+b];
        for (int b = 0; b < 4; b++) n += int'(s[t+7+b]) << b;
        last = t + HDR - 1 + n;
        rs = -1;
        for (int j = t; j <= last + 1; j++) if (rs < 0 && r[j]) rs = j;
        for (int e = t; e <= last; e++) begin
          if (rs >= 0 && e >= rs) break;
          pay = e >= t + HDR;
          expVec[e] = {1'b1, 1'(e == last), pay, pay & s[e], pay ? lb : 2'b0, pay ? pb : 4'b0};
        end
        i = (rs >= 0) ? rs + 1 : last + 2;
      end
    end
  endtask
  task automatic pin(input string nm, input logic [9:0] got, input logic [9:0] want);
    nCmp++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s model got %b want %b", nm, got, want);
    end
  endtask
  always @(posedge clk) begin
    if (running) begin
      #1;
      nCmp++;
      if ({busy, done, valid, serOut, LB, PB} !== expVec[curEdge]) begin
        nBad++;
        $display("FAIL edge%0d {busy,done,valid,serOut,LB,PB} got %b want %b",
                 curEdge, {busy, done, valid, serOut, LB, PB}, expVec[curEdge]);
      end
    end
  end
  initial begin
    int tA, tZ, tM, tM2, tR, tR2, tH, n, ra;
    logic [3:0] pb;
    logic [1:0] lb;
    logic [15:0] d;
    for (int e = 0; e < MAXL + PAD; e++) begin
      s[e] = 1'b1;
      r[e] = 1'b0;
    end
    pushBit(1'b1, 1'b1);
    pushBit(1'b1, 1'b1);
    repeat (20) pushBit(1'b1, 1'b0);
    pushFrame(4'b0101, 2'b10, 3, 16'h0005, 1'b1, -1);
    tA = lastStart;
    repeat (3) pushBit(1'b1, 1'b0);
    pushFrame(4'b1111, 2'b00, 0, 16'h0000, 1'b0, -1);
    tZ = lastStart;
    repeat (2) pushBit(1'b1, 1'b0);
    pushFrame(4'b1001, 2'b01, 15, 16'h5555, 1'b0, -1);
    tM = lastStart;
    pushFrame(4'b0010, 2'b11, 2, 16'h0002, 1'b1, -1);
    tM2 = lastStart;
    repeat (2) pushBit(1'b1, 1'b0);
    pushFrame(4'b1100, 2'b11, 5, 16'h0015, 1'b1, 12);
    tR = lastStart;
    pushFrame(4'b0011, 2'b01, 4, 16'h000b, 1'b1, -1);
    tR2 = lastStart;
    repeat (2) pushBit(1'b1, 1'b0);
    pushFrame(4'b0000, 2'b00, 2, 16'h0003, 1'b1, -1);
    tH = lastStart;
    repeat (3) pushBit(1'b1, 1'b0);
    repeat (40) begin
      n  = $urandom_range(0, 15);
      pb = 4'($urandom);
      lb = 2'($urandom);
      d  = 16'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, HDR + n) : -1;
      pushFrame(pb, lb, n, d, 1'($urandom_range(0, 1)), ra);
      repeat ($urandom_range(0, 3)) pushBit(1'b1, 1'b0);
    end
    repeat (30) pushBit(1'b1, 1'b0);
    buildModel();
    pin("basic_bit0",  expVec[tA+11], 10'b1_0_1_1_10_0101);
    pin("basic_bit1",  expVec[tA+12], 10'b1_0_1_0_10_0101);
    pin("basic_bit2",  expVec[tA+13], 10'b1_1_1_1_10_0101);
    pin("basic_after", expVec[tA+14], 10'b0);
    pin("zero_done",   expVec[tZ+10], 10'b1_1_0_0_00_0000);
    pin("zero_after",  expVec[tZ+11], 10'b0);
    pin("max_last",    expVec[tM+25], 10'b1_1_1_1_01_1001);
    pin("max_doneedge", expVec[tM+26], 10'b0);
    pin("b2b_start",   expVec[tM2], 10'b1_0_0_0_00_0000);
    pin("b2b_bit1",    expVec[tM2+12], 10'b1_1_1_1_11_0010);
    pin("rst_bit0",    expVec[tR+11], 10'b1_0_1_1_11_1100);
    pin("rst_cleared", expVec[tR+12], 10'b0);
    pin("rst_refr",    expVec[tR2+11], 10'b1_0_1_1_01_0011);
    pin("hdr0_bit1",   expVec[tH+12], 10'b1_1_1_1_00_0000);
    for (int i = 0; i < streamLen; i++) begin
      @(negedge clk);
      serIn   = s[i];
      rst     = r[i];
      curEdge = i;
      running = 1'b1;
    end
    @(posedge clk);
    #2;
    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
